// File: rtl/rename_commit_unit.sv
`timescale 1ns/1ps
// rename_commit_unit
// In-order retirement buffer that sits behind the register-rename stage.
// Renamed instructions are allocated in program order, each gets a rob_id,
// writebacks mark entries done out of order, and completed entries retire
// in order, up to INSTR_COUNT per cycle, returning ppreg to the free list.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   alloc_valid/lreg/preg/ppreg     per-lane allocate request (contiguous from lane 0)
//   alloc_ready                     room for a full INSTR_COUNT group this cycle
//   alloc_rob_id                    rob_id each lane would receive: (tail+i) mod ROB_DEPTH
//   wb_en, wb_rob_id                per-lane writeback completion
//   commit_valid/lreg/preg/ppreg    in-order retire group (contiguous from lane 0)
//   commit_ready                    free list accepts the whole group this cycle
//   flush                           synchronous clear of all entries
//   wb_err                          sticky: writeback hit an invalid or already-done entry
//   occupancy                       number of valid entries, 0..ROB_DEPTH
module rename_commit_unit #(
   parameter int P_REGISTERS = 64,
   parameter int L_REGISTERS = 32,
   parameter int C_NUM       = 4,
   parameter int K           = 32,
   parameter int INSTR_COUNT = 2,
   localparam int ROB_DEPTH  = (C_NUM - 1) * K,
   localparam int PW         = $clog2(P_REGISTERS),
   localparam int LW         = $clog2(L_REGISTERS),
   localparam int RW         = $clog2(ROB_DEPTH)
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [INSTR_COUNT-1:0]          alloc_valid,
   input  logic [INSTR_COUNT-1:0][LW-1:0]  alloc_lreg,
   input  logic [INSTR_COUNT-1:0][PW-1:0]  alloc_preg,
   input  logic [INSTR_COUNT-1:0][PW-1:0]  alloc_ppreg,
   output logic                            alloc_ready,
   output logic [INSTR_COUNT-1:0][RW-1:0]  alloc_rob_id,
   input  logic [INSTR_COUNT-1:0]          wb_en,
   input  logic [INSTR_COUNT-1:0][RW-1:0]  wb_rob_id,
   output logic [INSTR_COUNT-1:0]          commit_valid,
   output logic [INSTR_COUNT-1:0][LW-1:0]  commit_lreg,
   output logic [INSTR_COUNT-1:0][PW-1:0]  commit_preg,
   output logic [INSTR_COUNT-1:0][PW-1:0]  commit_ppreg,
   input  logic                            commit_ready,
   input  logic                            flush,
   output logic                            wb_err,
   output logic [RW:0]                     occupancy
);

   localparam logic [RW+1:0] DEPTH_W     = (RW+2)'(ROB_DEPTH);
   localparam logic [RW:0]   ALLOC_LIMIT = (RW+1)'(ROB_DEPTH - INSTR_COUNT);
   localparam logic [RW-1:0] LAST_ID     = RW'(ROB_DEPTH - 1);

   // Depth is not a power of two, so pointer arithmetic wraps explicitly.
   // offs never exceeds ROB_DEPTH, so one conditional subtract is enough.
   function automatic logic [RW-1:0] wrap_add(input logic [RW-1:0] base,
                                              input logic [RW:0]   offs);
      logic [RW+1:0] sum;
      sum = {2'b00, base} + {1'b0, offs};
      if (sum >= DEPTH_W) begin
         sum = sum - DEPTH_W;
      end
      return sum[RW-1:0];
   endfunction

   // Entry state
   logic [ROB_DEPTH-1:0] valid_reg, valid_next;
   logic [ROB_DEPTH-1:0] done_reg,  done_next;
   logic [LW-1:0]        lreg_mem  [ROB_DEPTH];
   logic [PW-1:0]        preg_mem  [ROB_DEPTH];
   logic [PW-1:0]        ppreg_mem [ROB_DEPTH];

   logic [RW-1:0] head_reg, tail_reg;
   logic [RW:0]   count_reg;
   logic          wb_err_reg;

   logic [RW-1:0]          head_idx [INSTR_COUNT];
   logic [RW-1:0]          tail_idx [INSTR_COUNT];
   logic [INSTR_COUNT-1:0] head_ok;
   logic [RW:0]            n_alloc, n_commit;
   logic                   wb_err_now;
   logic                   wb_dup;
   logic                   chain;

   // alloc_ready looks only at the registered count, so a commit in the
   // same cycle never opens room for an allocation.
   assign alloc_ready = (count_reg <= ALLOC_LIMIT);
   assign occupancy   = count_reg;
   assign wb_err      = wb_err_reg;

   for (genvar gi = 0; gi < INSTR_COUNT; gi++) begin : g_lane
      assign tail_idx[gi]     = wrap_add(tail_reg, (RW+1)'(gi));
      assign head_idx[gi]     = wrap_add(head_reg, (RW+1)'(gi));
      assign alloc_rob_id[gi] = tail_idx[gi];
      assign head_ok[gi]      = valid_reg[head_idx[gi]] & done_reg[head_idx[gi]];
      assign commit_lreg[gi]  = commit_valid[gi] ? lreg_mem[head_idx[gi]]  : '0;
      assign commit_preg[gi]  = commit_valid[gi] ? preg_mem[head_idx[gi]]  : '0;
      assign commit_ppreg[gi] = commit_valid[gi] ? ppreg_mem[head_idx[gi]] : '0;
   end

   // A lane may retire only if every older lane in the group also retires.
   always_comb begin
      chain        = 1'b1;
      commit_valid = '0;
      for (int i = 0; i < INSTR_COUNT; i++) begin
         chain           = chain & head_ok[i];
         commit_valid[i] = chain;
      end
   end

   // Lanes are contiguous, so popcount equals the number of active lanes.
   always_comb begin
      n_alloc  = '0;
      n_commit = '0;
      for (int i = 0; i < INSTR_COUNT; i++) begin
         if (alloc_ready) begin
            n_alloc = n_alloc + (RW+1)'(alloc_valid[i]);
         end
         if (commit_ready) begin
            n_commit = n_commit + (RW+1)'(commit_valid[i]);
         end
      end
   end

   // Retiring, allocated and written-back entries never overlap: retiring
   // entries are valid&done, allocated ones are invalid, and a writeback is
   // accepted only for valid&!done. Each update therefore touches distinct bits.
   always_comb begin
      valid_next = valid_reg;
      done_next  = done_reg;
      wb_err_now = 1'b0;
      wb_dup     = 1'b0;
      for (int i = 0; i < INSTR_COUNT; i++) begin
         if (commit_ready && commit_valid[i]) begin
            valid_next[head_idx[i]] = 1'b0;
            done_next[head_idx[i]]  = 1'b0;
         end
      end
      for (int i = 0; i < INSTR_COUNT; i++) begin
         if (alloc_ready && alloc_valid[i]) begin
            valid_next[tail_idx[i]] = 1'b1;
            done_next[tail_idx[i]]  = 1'b0;
         end
      end
      for (int i = 0; i < INSTR_COUNT; i++) begin
         if (wb_en[i]) begin
            // A second lane hitting the same rob_id is a double writeback.
            wb_dup = 1'b0;
            for (int j = 0; j < i; j++) begin
               if (wb_en[j] && (wb_rob_id[j] == wb_rob_id[i])) begin
                  wb_dup = 1'b1;
               end
            end
            if (wb_dup || (wb_rob_id[i] > LAST_ID) ||
                !valid_reg[wb_rob_id[i]] || done_reg[wb_rob_id[i]]) begin
               wb_err_now = 1'b1;
            end else begin
               done_next[wb_rob_id[i]] = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_reg  <= '0;
         done_reg   <= '0;
         head_reg   <= '0;
         tail_reg   <= '0;
         count_reg  <= '0;
         wb_err_reg <= 1'b0;
      end else if (flush) begin
         // Flush discards everything in flight but keeps the error flag.
         valid_reg <= '0;
         done_reg  <= '0;
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
      end else begin
         valid_reg  <= valid_next;
         done_reg   <= done_next;
         head_reg   <= wrap_add(head_reg, n_commit);
         tail_reg   <= wrap_add(tail_reg, n_alloc);
         count_reg  <= count_reg + n_alloc - n_commit;
         wb_err_reg <= wb_err_reg | wb_err_now;
      end
   end

   // Payload storage needs no reset: it is only observed through valid entries.
   always_ff @(posedge clk) begin
      for (int i = 0; i < INSTR_COUNT; i++) begin
         if (!flush && alloc_ready && alloc_valid[i]) begin
            lreg_mem[tail_idx[i]]  <= alloc_lreg[i];
            preg_mem[tail_idx[i]]  <= alloc_preg[i];
            ppreg_mem[tail_idx[i]] <= alloc_ppreg[i];
         end
      end
   end

endmodule

// File: tb/tb_rename_commit_unit.sv
`timescale 1ns/1ps
// tb_rename_commit_unit
// Directed bench for rename_commit_unit. Accepted allocations are pushed to
// a scoreboard queue; a commit monitor pops and compares them as the DUT
// retires. Directed steps check reset, ordering, full/wrap, hold, wb_err
// and flush behaviour.
module tb_rename_commit_unit;

   localparam int DEPTH = 96;
   localparam int LW    = 5;
   localparam int PW    = 6;
   localparam int RW    = 7;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic [1:0]            alloc_valid;
   logic [1:0][LW-1:0]    alloc_lreg;
   logic [1:0][PW-1:0]    alloc_preg;
   logic [1:0][PW-1:0]    alloc_ppreg;
   logic                  alloc_ready;
   logic [1:0][RW-1:0]    alloc_rob_id;
   logic [1:0]            wb_en;
   logic [1:0][RW-1:0]    wb_rob_id;
   logic [1:0]            commit_valid;
   logic [1:0][LW-1:0]    commit_lreg;
   logic [1:0][PW-1:0]    commit_preg;
   logic [1:0][PW-1:0]    commit_ppreg;
   logic                  commit_ready;
   logic                  flush;
   logic                  wb_err;
   logic [RW:0]           occupancy;

   rename_commit_unit dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .alloc_valid  (alloc_valid),
      .alloc_lreg   (alloc_lreg),
      .alloc_preg   (alloc_preg),
      .alloc_ppreg  (alloc_ppreg),
      .alloc_ready  (alloc_ready),
      .alloc_rob_id (alloc_rob_id),
      .wb_en        (wb_en),
      .wb_rob_id    (wb_rob_id),
      .commit_valid (commit_valid),
      .commit_lreg  (commit_lreg),
      .commit_preg  (commit_preg),
      .commit_ppreg (commit_ppreg),
      .commit_ready (commit_ready),
      .flush        (flush),
      .wb_err       (wb_err),
      .occupancy    (occupancy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int lreg;
      int preg;
      int ppreg;
   } ent_t;

   ent_t sb[$];
   ent_t mon_e;
   int   n_assert  = 0;
   int   n_fail    = 0;
   int   exp_tail  = 0;
   int   exp_head  = 0;
   int   exp_count = 0;
   int   seq       = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic reset_model();
      sb.delete();
      exp_tail  = 0;
      exp_head  = 0;
      exp_count = 0;
   endtask

   // One cycle: drive at negedge, check allocation side, let the edge pass.
   task automatic step(input logic [1:0] av,
                       input int lr0, input int pr0, input int pp0,
                       input int lr1, input int pr1, input int pp1,
                       input logic [1:0] we, input int w0, input int w1);
      bit model_ready;
      int n;
      @(negedge clk);
      alloc_valid    = av;
      alloc_lreg[0]  = LW'(lr0);
      alloc_preg[0]  = PW'(pr0);
      alloc_ppreg[0] = PW'(pp0);
      alloc_lreg[1]  = LW'(lr1);
      alloc_preg[1]  = PW'(pr1);
      alloc_ppreg[1] = PW'(pp1);
      wb_en          = we;
      wb_rob_id[0]   = RW'(w0);
      wb_rob_id[1]   = RW'(w1);
      #1;
      model_ready = (DEPTH - exp_count) >= 2;
      chk("alloc_ready", 32'(alloc_ready), 32'(model_ready));
      chk("occupancy", 32'(occupancy), exp_count);
      chk("alloc_rob_id0", 32'(alloc_rob_id[0]), exp_tail);
      chk("alloc_rob_id1", 32'(alloc_rob_id[1]), (exp_tail + 1) % DEPTH);
      n = int'(av[0]) + int'(av[1]);
      if (model_ready && !flush && n > 0) begin
         if (av[0]) sb.push_back('{lr0, pr0, pp0});
         if (av[1]) sb.push_back('{lr1, pr1, pp1});
         exp_tail  = (exp_tail + n) % DEPTH;
         exp_count = exp_count + n;
      end
      if (flush) reset_model();
      @(posedge clk);
      #1;
      alloc_valid = '0;
      wb_en       = '0;
   endtask

   task automatic idle();
      step(2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
   endtask

   task automatic wb1(input int w0);
      step(2'b00, 0, 0, 0, 0, 0, 0, 2'b01, w0, 0);
   endtask

   task automatic wb2(input int w0, input int w1);
      step(2'b00, 0, 0, 0, 0, 0, 0, 2'b11, w0, w1);
   endtask

   task automatic alloc_pair();
      step(2'b11, seq % 32, seq % 64, (seq * 7 + 1) % 64,
           (seq + 1) % 32, (seq + 1) % 64, (seq * 7 + 8) % 64, 2'b00, 0, 0);
      seq += 2;
   endtask

   // Commit monitor: each accepted retire lane must match the oldest entry.
   always @(posedge clk) begin
      if (rst_n && !flush && commit_ready) begin
         for (int i = 0; i < 2; i++) begin
            if (commit_valid[i]) begin
               n_assert++;
               assert (sb.size() != 0) else begin
                  n_fail++;
                  $error("FAIL commit_unexpected lane %0d: observed retire, expected empty", i);
               end
               if (sb.size() != 0) begin
                  mon_e = sb.pop_front();
                  chk("commit_lreg", 32'(commit_lreg[i]), mon_e.lreg);
                  chk("commit_preg", 32'(commit_preg[i]), mon_e.preg);
                  chk("commit_ppreg", 32'(commit_ppreg[i]), mon_e.ppreg);
                  exp_count = exp_count - 1;
                  exp_head  = (exp_head + 1) % DEPTH;
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int r;
      int hh;
      rst_n        = 1'b0;
      alloc_valid  = '0;
      alloc_lreg   = '0;
      alloc_preg   = '0;
      alloc_ppreg  = '0;
      wb_en        = '0;
      wb_rob_id    = '0;
      commit_ready = 1'b1;
      flush        = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_alloc_ready", 32'(alloc_ready), 1);
      chk("rst_commit_valid", 32'(commit_valid), 0);
      chk("rst_occupancy", 32'(occupancy), 0);
      chk("rst_wb_err", 32'(wb_err), 0);
      chk("rst_rob_id1", 32'(alloc_rob_id[1]), 1);
      chk("rst_commit_ppreg", 32'(commit_ppreg[0]), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Asynchronous reset mid-operation with 10 entries, two of them done
      commit_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         step(2'b11, 10 + 2*k, 20 + 2*k, 30 + 2*k, 11 + 2*k, 21 + 2*k, 31 + 2*k, 2'b00, 0, 0);
      end
      wb2(0, 1);
      chk("t1_cv_before_rst", 32'(commit_valid), 3);
      chk("t1_occ_before_rst", 32'(occupancy), 10);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t1_async_cv", 32'(commit_valid), 0);
      chk("t1_async_occ", 32'(occupancy), 0);
      chk("t1_async_ready", 32'(alloc_ready), 1);
      chk("t1_async_rob0", 32'(alloc_rob_id[0]), 0);
      chk("t1_async_rob1", 32'(alloc_rob_id[1]), 1);
      chk("t1_async_lreg", 32'(commit_lreg[1]), 0);
      reset_model();
      @(negedge clk);
      rst_n        = 1'b1;
      commit_ready = 1'b1;

      // Basic pair: wb out of order, retire together
      step(2'b11, 3, 40, 3, 5, 41, 5, 2'b00, 0, 0);
      wb1(1);
      chk("t2_cv_after_wb1", 32'(commit_valid), 0);
      wb1(0);
      chk("t2_cv_after_wb0", 32'(commit_valid), 3);
      chk("t2_ppreg0", 32'(commit_ppreg[0]), 3);
      chk("t2_ppreg1", 32'(commit_ppreg[1]), 5);
      chk("t2_preg0", 32'(commit_preg[0]), 40);
      chk("t2_lreg1", 32'(commit_lreg[1]), 5);
      idle();
      chk("t2_occ_after_commit", 32'(occupancy), 0);
      chk("t2_cv_empty", 32'(commit_valid), 0);

      // Out-of-order completion: oldest incomplete entry blocks younger ones
      r = exp_tail;
      step(2'b11, 1, 1, 11, 2, 2, 12, 2'b00, 0, 0);
      step(2'b11, 3, 3, 13, 4, 4, 14, 2'b00, 0, 0);
      wb2((r + 3) % DEPTH, (r + 2) % DEPTH);
      chk("t3_cv_blocked", 32'(commit_valid), 0);
      wb1(r);
      chk("t3_cv_lane0", 32'(commit_valid), 1);
      chk("t3_ppreg0", 32'(commit_ppreg[0]), 11);
      chk("t3_ppreg1_zero", 32'(commit_ppreg[1]), 0);
      idle();
      chk("t3_cv_rob1_blocks", 32'(commit_valid), 0);
      chk("t3_occ", 32'(occupancy), 3);
      wb1((r + 1) % DEPTH);
      chk("t3_cv_pair", 32'(commit_valid), 3);
      chk("t3_pair_ppreg0", 32'(commit_ppreg[0]), 12);
      chk("t3_pair_ppreg1", 32'(commit_ppreg[1]), 13);
      idle();
      chk("t3_cv_last", 32'(commit_valid), 1);
      chk("t3_last_ppreg", 32'(commit_ppreg[0]), 14);
      idle();
      chk("t3_occ_empty", 32'(occupancy), 0);

      // Fill to 96, held alloc ignored, then continuous wrap
      for (int k = 0; k < 48; k++) alloc_pair();
      chk("t4_full_ready", 32'(alloc_ready), 0);
      chk("t4_full_occ", 32'(occupancy), 96);
      alloc_pair();
      alloc_pair();
      chk("t4_held_occ", 32'(occupancy), 96);
      wb2(exp_head, (exp_head + 1) % DEPTH);
      chk("t4_cv_full", 32'(commit_valid), 3);
      chk("t4_ready_no_bypass", 32'(alloc_ready), 0);
      idle();
      chk("t4_ready_after_commit", 32'(alloc_ready), 1);
      chk("t4_occ_94", 32'(occupancy), 94);
      chk("t4_tail_pos", 32'(alloc_rob_id[0]), 6);
      for (int k = 0; k < 100; k++) begin
         step(2'b11, seq % 32, seq % 64, (seq * 7 + 1) % 64,
              (seq + 1) % 32, (seq + 1) % 64, (seq * 7 + 8) % 64,
              2'b11, exp_head, (exp_head + 1) % DEPTH);
         seq += 2;
         idle();
      end
      hh = exp_head;
      for (int k = 0; k < 47; k++) begin
         wb2(hh, (hh + 1) % DEPTH);
         hh = (hh + 2) % DEPTH;
      end
      idle();
      idle();
      chk("t4_drained_occ", 32'(occupancy), 0);
      chk("t4_no_wb_err", 32'(wb_err), 0);
      chk("t4_sb_empty", sb.size(), 0);

      // Hold: commit outputs stable while commit_ready is low
      commit_ready = 1'b0;
      r = exp_tail;
      step(2'b11, 7, 50, 21, 8, 51, 22, 2'b00, 0, 0);
      wb1(r);
      for (int k = 0; k < 5; k++) begin
         idle();
         chk("t5_hold_cv", 32'(commit_valid), 1);
         chk("t5_hold_ppreg", 32'(commit_ppreg[0]), 21);
         chk("t5_hold_lreg", 32'(commit_lreg[0]), 7);
         chk("t5_hold_occ", 32'(occupancy), 2);
      end
      commit_ready = 1'b1;
      idle();
      chk("t5_single_pop_occ", 32'(occupancy), 1);
      chk("t5_cv_after_pop", 32'(commit_valid), 0);
      wb1((r + 1) % DEPTH);
      idle();

      // Double writeback on the same rob_id
      r = exp_tail;
      step(2'b01, 9, 52, 23, 0, 0, 0, 2'b00, 0, 0);
      wb2(r, r);
      chk("t6_dup_wb_err", 32'(wb_err), 1);
      chk("t6_dup_cv", 32'(commit_valid), 1);
      idle();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_clears_err", 32'(wb_err), 0);
      reset_model();
      @(negedge clk);
      rst_n = 1'b1;

      // Writeback to an empty slot; sticky flag
      wb1(5);
      chk("t6_empty_wb_err", 32'(wb_err), 1);
      idle();
      idle();
      idle();
      chk("t6_err_sticky", 32'(wb_err), 1);

      // Flush with 20 valid entries, same-cycle alloc and wb dropped
      commit_ready = 1'b0;
      for (int k = 0; k < 10; k++) alloc_pair();
      wb2(0, 1);
      chk("t7_cv_pre_flush", 32'(commit_valid), 3);
      chk("t7_occ_pre_flush", 32'(occupancy), 20);
      flush = 1'b1;
      step(2'b11, 1, 2, 3, 4, 5, 6, 2'b11, 2, 3);
      flush = 1'b0;
      chk("t7_flush_occ", 32'(occupancy), 0);
      chk("t7_flush_cv", 32'(commit_valid), 0);
      chk("t7_flush_err_kept", 32'(wb_err), 1);
      chk("t7_flush_tail", 32'(alloc_rob_id[0]), 0);
      commit_ready = 1'b1;
      step(2'b11, 12, 60, 33, 13, 61, 34, 2'b00, 0, 0);
      wb2(0, 1);
      chk("t7_post_cv", 32'(commit_valid), 3);
      chk("t7_post_ppreg1", 32'(commit_ppreg[1]), 34);
      idle();
      idle();
      chk("t7_post_occ", 32'(occupancy), 0);
      chk("end_sb_empty", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
